// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen: run enable in, sync/position/strobes out.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
  logic       en;
  logic       hsync;
  logic       vsync;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       visible;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  modport master (
    input  en,
`ifdef VGA_FRAME_COUNT_EN
    output frame_count,
`endif
    output hsync, vsync, hpos, vpos, visible, line_start, frame_start
  );

  modport slave (
    output en,
`ifdef VGA_FRAME_COUNT_EN
    input  frame_count,
`endif
    input  hsync, vsync, hpos, vpos, visible, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-tick divider, h/v counters, registered sync/visible/strobes.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter on the interface.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int CLK_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic        SYNC_ACT = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hpos_q, hpos_d;
  logic [9:0]       vpos_q, vpos_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             visible_q, visible_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;

  always_comb begin
    tick   = vga.en && (div_q == DIV_LAST);
    h_wrap = (hpos_q == H_LAST);
    v_wrap = (vpos_q == V_LAST);

    div_d = div_q;
    if (vga.en) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (tick) begin
      if (h_wrap) begin
        hpos_d = '0;
        vpos_d = v_wrap ? '0 : vpos_q + 10'd1;
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end

    // Decode from the next counter values so sync/visible line up with hpos/vpos.
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    visible_d = visible_q;
    if (tick) begin
      hsync_d   = (({1'b0, hpos_d} >= HS_START) && ({1'b0, hpos_d} < HS_END)) ?
                  SYNC_ACT : ~SYNC_ACT;
      vsync_d   = (({1'b0, vpos_d} >= VS_START) && ({1'b0, vpos_d} < VS_END)) ?
                  SYNC_ACT : ~SYNC_ACT;
      visible_d = ({1'b0, hpos_d} < H_VIS) && ({1'b0, vpos_d} < V_VIS);
    end

    line_start_d  = tick && h_wrap;
    frame_start_d = tick && h_wrap && v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.frame_count = frame_count_q;
`endif

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.visible     = visible_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
